// File: rtl/dm_block_reader.sv
// dm_block_reader: streams a block of consecutive data-memory words onto a FIFO-buffered valid/ready output
module dm_block_reader #(
    parameter int MEMORY_ADDR_SIZE = 10,
    parameter int MEMORY_DATA_SIZE = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MEMORY_ADDR_SIZE-1:0] base_addr,
    input  logic [MEMORY_ADDR_SIZE:0]   length,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_readEn,
    output logic                        mem_writeEn,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_address,
    input  logic [MEMORY_DATA_SIZE-1:0] mem_dataOut,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MEMORY_DATA_SIZE-1:0] out_data,
    output logic                        out_last
);
    localparam int AW = MEMORY_ADDR_SIZE;
    localparam int DW = MEMORY_DATA_SIZE;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t         state;
    logic [AW-1:0]  base;
    logic [AW:0]    len;
    logic [AW:0]    issued;
    logic [AW:0]    popped;
    logic           inflight;
    logic [PW:0]    count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [DW-1:0]  fifo [FIFO_DEPTH];
    logic           issue;
    logic           pop;

    // a read is only issued when its returning word is guaranteed a free FIFO slot
    always_comb begin
        issue = state == READ && issued < len && 32'(count) + 32'(inflight) < FIFO_DEPTH;
        pop   = count != '0 && out_ready;
    end

    assign busy        = state == READ || state == DRAIN;
    assign done        = state == FIN;
    assign mem_readEn  = issue;
    assign mem_writeEn = 1'b0;
    assign mem_address = base + issued[AW-1:0];
    assign out_valid   = count != '0;
    assign out_data    = fifo[rd_ptr];
    assign out_last    = out_valid && popped + ONE == len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            len      <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else begin
            inflight <= issue;
            count    <= count + (PW+1)'(inflight) - (PW+1)'(pop);
            if (issue) issued <= issued + ONE;
            if (inflight) begin
                fifo[wr_ptr] <= mem_dataOut;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                popped <= popped + ONE;
            end
            case (state)
                IDLE: if (start) begin
                    base   <= base_addr;
                    len    <= length;
                    issued <= '0;
                    popped <= '0;
                    state  <= length == '0 ? FIN : READ;
                end
                READ:  if (issued == len) state <= DRAIN;
                // finish as the last word leaves, so done lands the cycle after its handshake
                DRAIN: if (!inflight && count == (PW+1)'(pop)) state <= FIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_block_reader.sv
// tb_dm_block_reader: directed scenarios against a synchronous 1-cycle-latency memory model
module tb_dm_block_reader;
    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy, done, mem_readEn, mem_writeEn, out_valid, out_last;
    logic [9:0]  mem_address;
    logic [15:0] mem_dataOut, out_data;
    logic [15:0] mem [1024];

    int          passed = 0, total = 0, cyc = 0;
    logic [9:0]  addr_q[$];
    logic [15:0] data_q[$];
    logic        last_q[$];
    int          rd_cyc[$], acc_cyc[$];
    int          done_cnt, valid_cnt, we_cnt, unstable;
    bit          hold;
    logic [15:0] hold_data;

    dm_block_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_readEn(mem_readEn), .mem_writeEn(mem_writeEn),
        .mem_address(mem_address), .mem_dataOut(mem_dataOut), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_readEn) mem_dataOut <= mem[mem_address];

    function automatic logic [15:0] f(input logic [9:0] a);
        return 16'(a) * 16'd37 + 16'h1234;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_readEn) begin addr_q.push_back(mem_address); rd_cyc.push_back(cyc); end
            if (mem_writeEn) we_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                data_q.push_back(out_data); last_q.push_back(out_last); acc_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (hold && (!out_valid || out_data !== hold_data)) unstable++;
        end
        hold = !rst && out_valid && !out_ready;
        hold_data = out_data;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clear;
        addr_q.delete(); data_q.delete(); last_q.delete(); rd_cyc.delete(); acc_cyc.delete();
        done_cnt = 0; valid_cnt = 0; we_cnt = 0; unstable = 0;
    endtask

    task automatic launch(input logic [9:0] b, input logic [10:0] l);
        clear();
        base_addr = b; length = l; start = 1'b1;
        tick();
        start = 1'b0; base_addr = '0; length = '0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            tick();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset;
        total++;
        if ({busy, done, mem_readEn, mem_writeEn, mem_address, out_valid, out_data, out_last} !== 32'h0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {busy, done, mem_readEn, mem_writeEn, mem_address, out_valid, out_data, out_last});
        else passed++;
    endtask

    task automatic test_basic;
        bit ok;
        out_ready = 1'b1;
        launch(10'h010, 11'd4);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else passed++;
        wait_done(40, ok);
        total++; if (!ok) $display("FAIL basic_timeout got=0 exp=1"); else passed++;
        total++;
        if (addr_q.size() != 4 || data_q.size() != 4)
            $display("FAIL basic_counts got=%0d/%0d exp=4/4", addr_q.size(), data_q.size());
        else passed++;
        for (int i = 0; i < 4 && i < addr_q.size() && i < data_q.size(); i++) begin
            total++;
            if (addr_q[i] !== 10'h010 + 10'(i)) $display("FAIL basic_addr%0d got=%h exp=%h", i, addr_q[i], 10'h010 + 10'(i));
            else passed++;
            total++;
            if (data_q[i] !== f(10'h010 + 10'(i))) $display("FAIL basic_data%0d got=%h exp=%h", i, data_q[i], f(10'h010 + 10'(i)));
            else passed++;
            total++;
            if (last_q[i] !== (i == 3)) $display("FAIL basic_last%0d got=%b exp=%b", i, last_q[i], i == 3);
            else passed++;
            total++;
            if (rd_cyc[i] - rd_cyc[0] != i || acc_cyc[i] - acc_cyc[0] != i)
                $display("FAIL basic_rate%0d got=%0d/%0d exp=%0d", i, rd_cyc[i] - rd_cyc[0], acc_cyc[i] - acc_cyc[0], i);
            else passed++;
        end
        if (rd_cyc.size() > 0 && acc_cyc.size() > 0) begin
            total++;
            if (acc_cyc[0] - rd_cyc[0] != 2) $display("FAIL basic_latency got=%0d exp=2", acc_cyc[0] - rd_cyc[0]);
            else passed++;
        end
        total++; if (done_cnt != 1) $display("FAIL basic_done_count got=%0d exp=1", done_cnt); else passed++;
        total++; if (we_cnt != 0) $display("FAIL basic_write_en got=%0d exp=0", we_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_zero_len;
        launch(10'h055, 11'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done got=%b%b exp=10", done, busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL zero_done_pulse got=%b exp=0", done); else passed++;
        repeat (3) tick();
        total++;
        if (addr_q.size() != 0 || valid_cnt != 0 || done_cnt != 1)
            $display("FAIL zero_activity got=%0d/%0d/%0d exp=0/0/1", addr_q.size(), valid_cnt, done_cnt);
        else passed++;
    endtask

    task automatic test_wrap;
        bit ok;
        logic [9:0] a;
        out_ready = 1'b1;
        launch(10'h3FE, 11'd4);
        wait_done(40, ok);
        total++;
        if (!ok || addr_q.size() != 4 || data_q.size() != 4)
            $display("FAIL wrap_counts got=%0d/%0d/%0d exp=1/4/4", ok, addr_q.size(), data_q.size());
        else passed++;
        for (int i = 0; i < addr_q.size() && i < data_q.size(); i++) begin
            a = 10'h3FE + 10'(i);
            total++;
            if (addr_q[i] !== a || data_q[i] !== f(a))
                $display("FAIL wrap_word%0d got=%h:%h exp=%h:%h", i, addr_q[i], data_q[i], a, f(a));
            else passed++;
        end
    endtask

    task automatic test_stall;
        bit ok;
        out_ready = 1'b0;
        launch(10'h100, 11'd8);
        repeat (10) tick();
        total++; if (addr_q.size() != 4) $display("FAIL stall_reads got=%0d exp=4", addr_q.size()); else passed++;
        total++;
        if (out_valid !== 1'b1 || out_data !== f(10'h100))
            $display("FAIL stall_head got=%b:%h exp=1:%h", out_valid, out_data, f(10'h100));
        else passed++;
        out_ready = 1'b1;
        wait_done(60, ok);
        total++;
        if (!ok || data_q.size() != 8 || addr_q.size() != 8)
            $display("FAIL stall_counts got=%0d/%0d/%0d exp=1/8/8", ok, data_q.size(), addr_q.size());
        else passed++;
        for (int i = 0; i < data_q.size(); i++) begin
            total++;
            if (data_q[i] !== f(10'h100 + 10'(i)) || last_q[i] !== (i == 7))
                $display("FAIL stall_word%0d got=%h/%b exp=%h/%b", i, data_q[i], last_q[i], f(10'h100 + 10'(i)), i == 7);
            else passed++;
        end
        total++; if (unstable != 0) $display("FAIL stall_stable got=%0d exp=0", unstable); else passed++;
        total++; if (done_cnt != 1) $display("FAIL stall_done_count got=%0d exp=1", done_cnt); else passed++;
    endtask

    task automatic test_ignore_start;
        bit ok;
        out_ready = 1'b1;
        launch(10'h020, 11'd5);
        tick();
        start = 1'b1; base_addr = 10'h200; length = 11'd2;
        tick();
        start = 1'b0; base_addr = '0; length = '0;
        wait_done(40, ok);
        total++;
        if (!ok || addr_q.size() != 5 || data_q.size() != 5 || done_cnt != 1)
            $display("FAIL ignore_counts got=%0d/%0d/%0d/%0d exp=1/5/5/1", ok, addr_q.size(), data_q.size(), done_cnt);
        else passed++;
        for (int i = 0; i < addr_q.size() && i < data_q.size(); i++) begin
            total++;
            if (addr_q[i] !== 10'h020 + 10'(i) || data_q[i] !== f(10'h020 + 10'(i)))
                $display("FAIL ignore_word%0d got=%h:%h exp=%h:%h", i, addr_q[i], data_q[i], 10'h020 + 10'(i), f(10'h020 + 10'(i)));
            else passed++;
        end
        repeat (5) tick();
        total++;
        if (busy !== 1'b0 || addr_q.size() != 5) $display("FAIL ignore_idle got=%b/%0d exp=0/5", busy, addr_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        out_ready = 1'b1;
        launch(10'h040, 11'd6);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (data_q.size() >= 2) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) $display("FAIL rmid_two_words got=%0d exp=2", data_q.size()); else passed++;
        rst = 1'b1;
        tick();
        test_reset();
        rst = 1'b0;
        clear();
        repeat (4) tick();
        total++;
        if (done_cnt != 0 || valid_cnt != 0 || addr_q.size() != 0)
            $display("FAIL rmid_quiet got=%0d/%0d/%0d exp=0/0/0", done_cnt, valid_cnt, addr_q.size());
        else passed++;
        launch(10'h060, 11'd3);
        wait_done(40, ok);
        total++;
        if (!ok || data_q.size() != 3 || done_cnt != 1)
            $display("FAIL rmid_restart got=%0d/%0d/%0d exp=1/3/1", ok, data_q.size(), done_cnt);
        else passed++;
        for (int i = 0; i < data_q.size(); i++) begin
            total++;
            if (data_q[i] !== f(10'h060 + 10'(i)) || last_q[i] !== (i == 2))
                $display("FAIL rmid_word%0d got=%h/%b exp=%h/%b", i, data_q[i], last_q[i], f(10'h060 + 10'(i)), i == 2);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = f(10'(i));
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        clear();
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_zero_len();
        test_wrap();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
